// File: rtl/wave_channel_sched.sv
// wave_channel_sched: round-robin scheduler feeding four channels' parameters to one shared compute datapath.
// Define SCHED_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles (result 12'hFFF, sticky timeout_err).
module wave_channel_sched #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_ch,
    input  logic [1:0]  cfg_sel,
    input  logic [11:0] cfg_data,
    input  logic [3:0]  ch_en,
    output logic [11:0] cmp_amp,
    output logic [11:0] cmp_phaseoffset,
    output logic [11:0] cmp_deltat,
    output logic [11:0] cmp_freq,
    output logic        cmp_start,
    input  logic        cmp_done,
    input  logic [11:0] cmp_result,
    output logic        out_valid,
    output logic [1:0]  out_ch,
    output logic [11:0] out_data,
    output logic        busy
`ifdef SCHED_TIMEOUT_EN
   ,output logic        timeout_err
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be within 1..255");
    end

    state_t      state_q;
    logic [11:0] par_q [4][4];
    logic [1:0]  last_q, ch_q, pick;
`ifdef SCHED_TIMEOUT_EN
    logic [7:0]  cnt_q;
`endif

    // Scan downward so the enabled channel nearest after last_q wins.
    always_comb begin
        pick = last_q;
        for (int i = 4; i >= 1; i--)
            if (ch_en[2'(last_q + 2'(i))]) pick = 2'(last_q + 2'(i));
    end

    assign busy = state_q != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            last_q          <= 2'd3;
            ch_q            <= '0;
            cmp_amp         <= '0;
            cmp_phaseoffset <= '0;
            cmp_deltat      <= '0;
            cmp_freq        <= '0;
            cmp_start       <= 1'b0;
            out_valid       <= 1'b0;
            out_ch          <= '0;
            out_data        <= '0;
            for (int c = 0; c < 4; c++)
                for (int s = 0; s < 4; s++)
                    par_q[c][s] <= '0;
`ifdef SCHED_TIMEOUT_EN
            cnt_q           <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
            if (cfg_we) par_q[cfg_ch][cfg_sel] <= cfg_data;
            cmp_start <= 1'b0;
            out_valid <= 1'b0;
            case (state_q)
                IDLE: if (|ch_en) begin
                    ch_q            <= pick;
                    cmp_amp         <= par_q[pick][0];
                    cmp_phaseoffset <= par_q[pick][1];
                    cmp_deltat      <= par_q[pick][2];
                    cmp_freq        <= par_q[pick][3];
                    cmp_start       <= 1'b1;
                    state_q         <= ISSUE;
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef SCHED_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: if (cmp_done) begin
                    out_data  <= cmp_result;
                    out_ch    <= ch_q;
                    out_valid <= 1'b1;
                    state_q   <= STORE;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    out_data    <= 12'hFFF;
                    out_ch      <= ch_q;
                    out_valid   <= 1'b1;
                    timeout_err <= 1'b1;
                    state_q     <= STORE;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
`endif
                STORE: begin
                    last_q  <= ch_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
